// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM pipeline memory-stage blocks.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } sram_state_t;

  localparam logic [31:0] DATA_MEM_BASE = 32'd1024;

endpackage

// File: rtl/sram_ctrl.sv
// MEM-stage data memory responder: one 32-bit access as two 16-bit SRAM phases.
// Optional one-entry read buffer enabled with `define SRAM_CTRL_RDBUF_EN.
module sram_ctrl
  import arm_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int unsigned WW       = ADDR_W - 1;
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);

  sram_state_t    state_q;
  logic [3:0]     cnt_q;
  logic           wr_q;
  logic [WW-1:0]  word_q;
  logic [15:0]    wdata_hi_q;
  logic [31:0]    rdata_q;
  logic [WW-1:0]  word;
  logic           req;
  logic           hit;

  assign req  = mem_r_en | mem_w_en;
  // Word index wraps modulo the SRAM size; upper address bits are dropped.
  assign word = WW'((addr - DATA_MEM_BASE) >> 2);

`ifdef SRAM_CTRL_RDBUF_EN
  logic          buf_valid_q;
  logic [WW-1:0] buf_word_q;
  logic [31:0]   buf_data_q;

  assign hit   = (state_q == IDLE) && mem_r_en && !mem_w_en &&
                 buf_valid_q && (buf_word_q == word);
  assign rdata = hit ? buf_data_q : rdata_q;
`else
  assign hit   = 1'b0;
  assign rdata = rdata_q;
`endif

  assign ready = (state_q == DONE) || ((state_q == IDLE) && !req) || hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      word_q     <= '0;
      wdata_hi_q <= '0;
      rdata_q    <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
`ifdef SRAM_CTRL_RDBUF_EN
      buf_valid_q <= 1'b0;
      buf_word_q  <= '0;
      buf_data_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !hit) begin
            state_q   <= LO;
            cnt_q     <= CNT_INIT;
            wr_q      <= mem_w_en;
            word_q    <= word;
            sram_addr <= {word, 1'b0};
            if (mem_w_en) begin
              wdata_hi_q <= wdata[31:16];
              sram_dq_o  <= wdata[15:0];
              sram_dq_oe <= 1'b1;
              sram_we_n  <= 1'b0;
`ifdef SRAM_CTRL_RDBUF_EN
              buf_valid_q <= 1'b0;
`endif
            end else begin
              sram_oe_n <= 1'b0;
            end
          end
`ifdef SRAM_CTRL_RDBUF_EN
          // Keep the buffered value visible after the hit request drops.
          if (hit) rdata_q <= buf_data_q;
`endif
        end
        LO: begin
          if (cnt_q == '0) begin
            state_q   <= HI;
            cnt_q     <= CNT_INIT;
            sram_addr <= {word_q, 1'b1};
            if (wr_q) sram_dq_o <= wdata_hi_q;
            else      rdata_q[15:0] <= sram_dq_i;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HI: begin
          if (cnt_q == '0) begin
            state_q    <= DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            if (!wr_q) begin
              rdata_q[31:16] <= sram_dq_i;
`ifdef SRAM_CTRL_RDBUF_EN
              buf_valid_q <= 1'b1;
              buf_word_q  <= word_q;
              buf_data_q  <= {sram_dq_i, rdata_q[15:0]};
`endif
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: word-level reference memory plus a
// half-word SRAM model driven by the controller's bus outputs.
module tb_sram_ctrl;
  import arm_pkg::*;

  localparam int unsigned W  = 2;
  localparam int unsigned AW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_r_en = 1'b0;
  logic          mem_w_en = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_o;
  logic [15:0]   sram_dq_i = '0;
  logic          sram_dq_oe;
  logic          sram_we_n;
  logic          sram_oe_n;

  int checks = 0;
  int errors = 0;

  sram_ctrl #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  // External asynchronous SRAM, half-word addressed.
  logic [15:0] sram [logic [AW-1:0]];

  always @(posedge clk)
    if (rst && !sram_we_n && sram_dq_oe) sram[sram_addr] = sram_dq_o;

  always @(negedge clk)
    if (!sram_oe_n) sram_dq_i = sram.exists(sram_addr) ? sram[sram_addr] : 16'h0;
    else            sram_dq_i = 16'($urandom);

  // Reference: 32-bit words indexed by mapped word, plus buffer bookkeeping.
  logic [31:0]   ref_mem [logic [AW-2:0]];
  logic [31:0]   last_load = '0;
  bit            bvalid = 1'b0;
  logic [AW-2:0] bword = '0;

  function automatic logic [AW-2:0] map_word(input logic [31:0] a);
    return (AW-1)'((a - 32'd1024) / 32'd4);
  endfunction

  function automatic logic [31:0] ref_read(input logic [AW-2:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input string name);
    logic [AW-2:0] w = map_word(a);
    bit            is_rd = rd && !wr;
    bit            hit = 1'b0;
    int            lat = -1;
    int            exp_lat;
    logic [31:0]   exp_data = ref_read(w);
    logic [31:0]   got = '0;
    logic [63:0]   we_mask = '0, oe_mask = '0, exp_we = '0, exp_oe = '0;
    logic [AW-1:0] lo_a = {w, 1'b0};
    logic [AW-1:0] hi_a = {w, 1'b1};
`ifdef SRAM_CTRL_RDBUF_EN
    hit = is_rd && bvalid && (bword == w);
`endif
    exp_lat = hit ? 0 : 2 * W + 1;
    if (!hit)
      for (int c = 1; c <= 2 * W; c++) begin
        if (wr)    exp_we[c] = 1'b1;
        if (is_rd) exp_oe[c] = 1'b1;
      end

    @(posedge clk); #1;
    mem_r_en = rd; mem_w_en = wr; addr = a; wdata = d;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!sram_we_n) we_mask[c] = 1'b1;
      if (!sram_oe_n) oe_mask[c] = 1'b1;
      if (ready) begin lat = c; got = rdata; break; end
      @(posedge clk); #1;
      if (c == 0) begin addr = $urandom; wdata = $urandom; end
    end
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0;

    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (we_mask !== exp_we) begin
      errors++; $display("FAIL %s we_n cycles: got %h expected %h", name, we_mask, exp_we);
    end
    checks++;
    if (oe_mask !== exp_oe) begin
      errors++; $display("FAIL %s oe_n cycles: got %h expected %h", name, oe_mask, exp_oe);
    end
    checks++;
    if (is_rd) begin
      if (got !== exp_data) begin
        errors++; $display("FAIL %s rdata: got %h expected %h", name, got, exp_data);
      end
      last_load = exp_data; bvalid = 1'b1; bword = w;
    end else begin
      if (got !== last_load) begin
        errors++; $display("FAIL %s rdata hold: got %h expected %h", name, got, last_load);
      end
      checks += 2;
      if (!sram.exists(lo_a) || sram[lo_a] !== d[15:0]) begin
        errors++; $display("FAIL %s sram lo: got %h expected %h", name,
                           sram.exists(lo_a) ? sram[lo_a] : 16'hxxxx, d[15:0]);
      end
      if (!sram.exists(hi_a) || sram[hi_a] !== d[31:16]) begin
        errors++; $display("FAIL %s sram hi: got %h expected %h", name,
                           sram.exists(hi_a) ? sram[hi_a] : 16'hxxxx, d[31:16]);
      end
      ref_mem[w] = d; bvalid = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string name, input bit exp_ready);
    logic [AW+33:0] got = {rdata, sram_addr, sram_dq_o[15:14], 2'b00};
    checks++;
    if (rdata !== '0 || sram_addr !== '0 || sram_dq_o !== '0 || sram_dq_oe !== 1'b0 ||
        sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin
      errors++;
      $display("FAIL %s outputs: got rdata=%h addr=%h dq=%h oe=%b we_n=%b oe_n=%b expected zeros, we_n=1 oe_n=1 (%h)",
               name, rdata, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, sram_oe_n, got);
    end
    checks++;
    if (ready !== exp_ready) begin
      errors++; $display("FAIL %s ready: got %b expected %b", name, ready, exp_ready);
    end
  endtask

  task automatic test_reset;
    #12;
    check_idle_outputs("reset", 1'b1);
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL reset state: got %0d expected %0d", dut.state_q, IDLE);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_store;
    do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, "store1032");
  endtask

  task automatic test_load;
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, "load1032");
  endtask

  task automatic test_both_enables;
    do_access(1'b1, 1'b1, 32'd1024, 32'h12345678, "both1024");
  endtask

  task automatic test_held_load;
    logic [63:0]   rmask = '0, exp = '0;
    logic [AW-2:0] w = map_word(32'd1032);
    exp[2*W+1] = 1'b1;
`ifdef SRAM_CTRL_RDBUF_EN
    for (int c = 2*W+2; c <= 4*W+3; c++) exp[c] = 1'b1;
`else
    exp[4*W+3] = 1'b1;
`endif
    @(posedge clk); #1;
    mem_r_en = 1'b1; addr = 32'd1032;
    for (int c = 0; c <= 4*W+3; c++) begin
      @(negedge clk);
      if (ready) rmask[c] = 1'b1;
      @(posedge clk); #1;
    end
    mem_r_en = 1'b0;
    checks++;
    if (rmask !== exp) begin
      errors++; $display("FAIL held_load ready pulses: got %h expected %h", rmask, exp);
    end
    last_load = ref_read(w); bvalid = 1'b1; bword = w;
    checks++;
    if (rdata !== last_load) begin
      errors++; $display("FAIL held_load rdata: got %h expected %h", rdata, last_load);
    end
  endtask

  task automatic test_reset_mid_store;
    logic [AW-2:0] w = map_word(32'd1100);
    @(posedge clk); #1;
    mem_w_en = 1'b1; addr = 32'd1100; wdata = $urandom;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_mid_req", 1'b0);
    mem_w_en = 1'b0;
    #1;
    check_idle_outputs("rst_mid_noreq", 1'b1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("rst_release", 1'b1);
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL rst_release state: got %0d expected %0d", dut.state_q, IDLE);
    end
    last_load = '0; bvalid = 1'b0;
    ref_mem.delete(w);
    sram.delete({w, 1'b0}); sram.delete({w, 1'b1});
  endtask

  task automatic test_rdbuf;
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, "rdbuf_load_a");
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, "rdbuf_load_b");
    do_access(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, "rdbuf_store");
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, "rdbuf_load_c");
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      int unsigned op    = $urandom_range(0, 3);
      logic [31:0] alias_off = 32'($urandom_range(0, 3)) << (AW + 1);
      logic [31:0] a = 32'd1024 + 32'd4 * 32'($urandom_range(0, 15)) +
                       alias_off + 32'($urandom_range(0, 3));
      do_access(op != 2, op >= 2, a, $urandom, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_store();
    test_load();
    test_both_enables();
    test_held_load();
    test_reset_mid_store();
    test_rdbuf();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
